alu_seq: RTL and testbench

- Parametrised, handshaked successor to the 4-bit combinational ALU.
- Operand width is configurable. Results and flags are registered.
- Adds an unsigned-compare op and an iterative shift-add multiply, run by a small state machine.
- Sits between the operand-fetch stage and writeback. Valid/ready handshakes on both sides.

---
 rtl/alu_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_seq.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked, parametrised ALU with registered result/flags and an
// iterative shift-add multiplier (one partial product per cycle).
// Optional sticky carry/overflow status is compiled in with ALU_SEQ_STICKY_EN.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OpCode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             SLT_Flag,
    output logic             Zero_Flag,
    output logic             Carry_Flag,
    output logic             Overflow_Flag,
    input  logic             sticky_clr,
    output logic             Sticky_Carry,
    output logic             Sticky_Ovf
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_e;

    state_e               state_q, state_d;
    logic                 rdy_en_q;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 slt_q, slt_d, zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

    logic                 accept, mul_start, mul_done;
    logic [2*WIDTH-1:0]   acc_sum;
    logic [WIDTH:0]       sum, diff;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_c, alu_o, alu_slt;

    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (OpCode == OP_MUL);
    assign mul_done  = (state_q == S_MUL) && (cnt_q == CNT_W'(1));
    // The accumulator value after this cycle's partial product; also the final product on mul_done.
    assign acc_sum   = acc_q + (mplier_q[0] ? mcand_q : '0);

    // State register; rdy_en_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    // Next state: a MUL accept enters S_MUL, the last iteration returns to S_IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (mul_start) state_d = S_MUL;
            S_MUL:   if (mul_done)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output: accept only when idle and the output slot is free or draining this cycle.
    always_comb begin
        in_ready = rdy_en_q && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    end

    // Single-cycle ALU ops; borrow is the top bit of the widened difference.
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        alu_slt = 1'b0;
        case (OpCode)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_o   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_o   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_XOR:  alu_res = A ^ B;
            OP_SLT: begin
                alu_slt = $signed(A) < $signed(B);
                alu_res = {{(WIDTH-1){1'b0}}, alu_slt};
            end
            OP_SLTU: begin
                alu_slt = A < B;
                alu_res = {{(WIDTH-1){1'b0}}, alu_slt};
            end
            default: ;
        endcase
    end

    // Multiplier datapath: load on accept, then one shift-add step per cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (mul_start) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = CNT_W'(WIDTH);
        end else if (state_q == S_MUL) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - CNT_W'(1);
        end
    end

    // Output register: holds under backpressure, loads ALU ops at accept and MUL on completion.
    always_comb begin
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        slt_d       = slt_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        if (accept && (OpCode != OP_MUL)) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            slt_d       = alu_slt;
            zero_d      = (alu_res == '0);
            carry_d     = alu_c;
            ovf_d       = alu_o;
        end else if (mul_done) begin
            out_valid_d = 1'b1;
            result_d    = acc_sum[WIDTH-1:0];
            slt_d       = 1'b0;
            zero_d      = (acc_sum[WIDTH-1:0] == '0);
            carry_d     = |acc_sum[2*WIDTH-1:WIDTH];
            ovf_d       = 1'b0;
        end
    end

    // Datapath and output flops; reset abandons any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            slt_q       <= 1'b0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            slt_q       <= slt_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign Result        = result_q;
    assign SLT_Flag      = slt_q;
    assign Zero_Flag     = zero_q;
    assign Carry_Flag    = carry_q;
    assign Overflow_Flag = ovf_q;

`ifdef ALU_SEQ_STICKY_EN
    logic sticky_c_q, sticky_c_d, sticky_o_q, sticky_o_d;
    logic out_xfer;

    assign out_xfer = out_valid_q && out_ready;

    // Sticky status: a transferred flag sets, a clear pulse resets; set has priority.
    always_comb begin
        sticky_c_d = sticky_c_q;
        sticky_o_d = sticky_o_q;
        if (out_xfer && carry_q) sticky_c_d = 1'b1;
        else if (sticky_clr)     sticky_c_d = 1'b0;
        if (out_xfer && ovf_q)   sticky_o_d = 1'b1;
        else if (sticky_clr)     sticky_o_d = 1'b0;
    end

    // Sticky status flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_c_q <= 1'b0;
            sticky_o_q <= 1'b0;
        end else begin
            sticky_c_q <= sticky_c_d;
            sticky_o_q <= sticky_o_d;
        end
    end

    assign Sticky_Carry = sticky_c_q;
    assign Sticky_Ovf   = sticky_o_q;
`else
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
    assign Sticky_Carry      = 1'b0;
    assign Sticky_Ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus random stimulus for alu_seq (WIDTH=8), checked
// against an arithmetic reference model and an expected-result queue.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, out_ready = 1'b0, sticky_clr = 1'b0;
    logic [W-1:0] A = '0, B = '0;
    logic [2:0]   OpCode = '0;
    logic         in_ready, out_valid, SLT_Flag, Zero_Flag, Carry_Flag, Overflow_Flag;
    logic         Sticky_Carry, Sticky_Ovf;
    logic [W-1:0] Result;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .OpCode(OpCode), .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .SLT_Flag(SLT_Flag), .Zero_Flag(Zero_Flag),
        .Carry_Flag(Carry_Flag), .Overflow_Flag(Overflow_Flag),
        .sticky_clr(sticky_clr), .Sticky_Carry(Sticky_Carry), .Sticky_Ovf(Sticky_Ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] r;
        logic         slt, z, c, o;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0, fails = 0, cyc = 0, last_lat = -1;
    bit   accepted = 0, rnd_rdy = 0;
    logic exp_sc = 1'b0, exp_so = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint m  = longint'(1) << W;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = (ua >= m / 2) ? ua - m : ua;
        longint sb = (ub >= m / 2) ? ub - m : ub;
        longint v  = 0;
        e.c = 1'b0; e.o = 1'b0; e.slt = 1'b0; e.acc = 0;
        case (op)
            3'd0: begin v = ua + ub; e.c = (v >= m);
                        e.o = (sa + sb >= m / 2) || (sa + sb < -(m / 2)); end
            3'd1: begin v = ua - ub; e.c = (ua < ub);
                        e.o = (sa - sb >= m / 2) || (sa - sb < -(m / 2));
                        if (v < 0) v = v + m; end
            3'd2: v = ua & ub;
            3'd3: v = ua | ub;
            3'd4: v = ua ^ ub;
            3'd5: begin e.slt = (sa < sb); v = e.slt ? 1 : 0; end
            3'd6: begin e.slt = (ua < ub); v = e.slt ? 1 : 0; end
            default: begin v = ua * ub; e.c = (v >= m); end
        endcase
        e.r = W'(v % m);
        e.z = (e.r == '0);
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(5))
            0: return '0;
            1: return {W{1'b1}};
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // One clock: observe at negedge (transfers, accepts, sticky), then advance past posedge.
    task automatic cycle();
        exp_t e;
        logic nsc, nso;
        @(negedge clk);
        cyc++;
        accepted = 0;
        chk("sticky_c", {31'b0, Sticky_Carry}, {31'b0, exp_sc});
        chk("sticky_o", {31'b0, Sticky_Ovf}, {31'b0, exp_so});
        nsc = exp_sc; nso = exp_so;
        if (out_valid && out_ready) begin
            chk("spurious_out", {31'b0, q.size() == 0}, 0);
            if (q.size() != 0) begin
                e = q.pop_front();
                last_lat = cyc - e.acc;
                chk("result", {Result, SLT_Flag, Zero_Flag, Carry_Flag, Overflow_Flag},
                              {e.r, e.slt, e.z, e.c, e.o});
`ifdef ALU_SEQ_STICKY_EN
                if (e.c) nsc = 1'b1; else if (sticky_clr) nsc = 1'b0;
                if (e.o) nso = 1'b1; else if (sticky_clr) nso = 1'b0;
`endif
            end
        end else begin
`ifdef ALU_SEQ_STICKY_EN
            if (sticky_clr) begin nsc = 1'b0; nso = 1'b0; end
`endif
        end
        exp_sc = nsc; exp_so = nso;
        if (in_valid && in_ready) begin
            e = model(OpCode, A, B);
            e.acc = cyc;
            q.push_back(e);
            accepted = 1;
        end
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1; OpCode = op; A = a; B = b;
        for (int k = 0; k < 64; k++) begin
            cycle();
            if (accepted) break;
        end
        chk("accepted", {31'b0, accepted}, 1);
        in_valid = 1'b0;
        A = W'($urandom); B = W'($urandom); OpCode = 3'($urandom);
    endtask

    initial begin
        int low_cnt, seen;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_outputs", {Result, SLT_Flag, Zero_Flag, Carry_Flag, Overflow_Flag, Sticky_Carry, Sticky_Ovf}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready_low", {31'b0, in_ready}, 0);
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", {31'b0, in_ready}, 1);
        out_ready = 1'b1;

        // Directed arithmetic cases
        issue(3'd0, 8'hFF, 8'h01); cycle();
        chk("add_lat", last_lat, 1);
        chk("add_wrap", {Result, Zero_Flag, Carry_Flag, Overflow_Flag}, {8'h00, 3'b110});
        issue(3'd0, 8'h7F, 8'h01); cycle();
        chk("add_ovf", {Result, Carry_Flag, Overflow_Flag}, {8'h80, 2'b01});
        issue(3'd1, 8'h80, 8'h01); cycle();
        chk("sub_ovf", {Result, Overflow_Flag}, {8'h7F, 1'b1});
        issue(3'd1, 8'h05, 8'h07); cycle();
        chk("sub_borrow", {Result, Carry_Flag, Overflow_Flag}, {8'hFE, 2'b10});
        issue(3'd5, 8'hF9, 8'h02); cycle();
        chk("slt", {Result, SLT_Flag}, {8'h01, 1'b1});
        issue(3'd6, 8'hF9, 8'h02); cycle();
        chk("sltu", {Result, SLT_Flag, Zero_Flag}, {8'h00, 2'b01});

        // Multiply latency and stall
        issue(3'd7, 8'h10, 8'h20);
        low_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) break;
            if (!in_ready) low_cnt++;
            cycle();
        end
        chk("mul_busy_cycles", low_cnt, 8);
        cycle();
        chk("mul_lat", last_lat, 9);
        chk("mul_res", {Result, Zero_Flag, Carry_Flag}, {8'h00, 2'b11});
        chk("mul_in_ready", {31'b0, in_ready}, 1);
        issue(3'd7, 8'h0D, 8'h0B);
        for (int k = 0; k < 20 && !out_valid; k++) cycle();
        cycle();
        chk("mul_small", {Result, Carry_Flag}, {8'h8F, 1'b0});

        // Backpressure: first result held, second op waits
        out_ready = 1'b0;
        issue(3'd4, 8'hA5, 8'h3C);
        in_valid = 1'b1; OpCode = 3'd3; A = 8'h0F; B = 8'hF0;
        repeat (4) begin
            cycle();
            chk("bp_in_ready", {31'b0, in_ready}, 0);
            chk("bp_hold", {out_valid, Result}, {1'b1, 8'h99});
        end
        out_ready = 1'b1;
        issue(3'd3, 8'h0F, 8'hF0);
        issue(3'd1, 8'h05, 8'h07);
        chk("bp_stream2_lat", last_lat, 1);
        cycle();
        chk("bp_stream3_lat", last_lat, 1);
        chk("bp_last", Result, 8'hFE);

        // Sticky overflow survives a later clean op until cleared
        issue(3'd0, 8'h7F, 8'h01); cycle();
        issue(3'd2, 8'hFF, 8'h0F); cycle();
`ifdef ALU_SEQ_STICKY_EN
        chk("sticky_held", {31'b0, Sticky_Ovf}, 1);
`else
        chk("sticky_off", {31'b0, Sticky_Ovf}, 0);
`endif
        sticky_clr = 1'b1; cycle(); sticky_clr = 1'b0; cycle();
        chk("sticky_cleared", {31'b0, Sticky_Ovf}, 0);

        // Reset in the middle of a multiply
        issue(3'd7, 8'h33, 8'h05);
        repeat (4) cycle();
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        chk("midrst_in_ready", {31'b0, in_ready}, 0);
        q.delete();
        exp_sc = 1'b0; exp_so = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        repeat (12) begin
            cycle();
            if (out_valid) seen++;
        end
        chk("no_stale_result", seen, 0);

        // Random ops with random backpressure and clear pulses
        rnd_rdy = 1;
        for (int n = 0; n < 300; n++) begin
            sticky_clr = ($urandom_range(7) == 0);
            issue(3'($urandom_range(7)), pick(), pick());
        end
        sticky_clr = 1'b0;
        rnd_rdy = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 40 && q.size() != 0; k++) cycle();
        chk("drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
